// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the frame-buffer write port, with an optional full-frame clear
// sequencer that is compiled in when FB_ARB_CLEAR_EN is defined.
module fb_write_arbiter #(
   parameter int unsigned FB_W = 160,
   parameter int unsigned FB_H = 120
) (
   input  logic       clock,
   input  logic       not_reset,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_x,
   input  logic [7:0] req0_y,
   input  logic [8:0] req0_rgb,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_x,
   input  logic [7:0] req1_y,
   input  logic [8:0] req1_rgb,
   input  logic       clear_start,
   input  logic [8:0] clear_rgb,
   output logic       clear_busy,
   output logic [7:0] oX,
   output logic [7:0] oY,
   output logic [2:0] oR,
   output logic [2:0] oG,
   output logic [2:0] oB,
   output logic       oWE
);

   logic       r_last_grant;
   logic       r_we;
   logic [7:0] r_x;
   logic [7:0] r_y;
   logic [8:0] r_rgb;

   logic       w_grant;
   logic       w_arb_open;
   logic       w_xfer;
   logic       w_last_grant_d;
   logic       w_we_d;
   logic [7:0] w_x_d;
   logic [7:0] w_y_d;
   logic [8:0] w_rgb_d;

`ifdef FB_ARB_CLEAR_EN
   localparam logic [7:0] XLast = 8'(FB_W - 1);
   localparam logic [7:0] YLast = 8'(FB_H - 1);

   typedef enum logic [0:0] {StArb, StClear} state_t;

   state_t     r_state;
   state_t     w_state_d;
   logic [7:0] r_cx;
   logic [7:0] r_cy;
   logic [8:0] r_crgb;
   logic       r_busy;
   logic [7:0] w_cx_d;
   logic [7:0] w_cy_d;
   logic [8:0] w_crgb_d;
   logic       w_busy_d;
   logic       w_clear_go;
   logic [7:0] w_pos_x;
   logic [7:0] w_pos_y;

   assign w_clear_go = (r_state == StClear) | clear_start;
   assign w_arb_open = not_reset & (r_state == StArb) & ~clear_start;
   // The first clear write (0,0) is issued in the start cycle itself.
   assign w_pos_x    = (r_state == StClear) ? r_cx : 8'd0;
   assign w_pos_y    = (r_state == StClear) ? r_cy : 8'd0;
   assign clear_busy = r_busy;
`else
   logic w_unused_clear;

   assign w_unused_clear = ^{clear_start, clear_rgb};
   assign w_arb_open     = not_reset;
   assign clear_busy     = 1'b0;
`endif

   // Under contention the requester not granted most recently wins.
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid & req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end
   end

   assign req0_ready = w_arb_open & req0_valid & ~w_grant;
   assign req1_ready = w_arb_open & req1_valid & w_grant;
   assign w_xfer     = req0_ready | req1_ready;

   always_comb begin
      w_last_grant_d = r_last_grant;
      w_we_d         = 1'b0;
      w_x_d          = r_x;
      w_y_d          = r_y;
      w_rgb_d        = r_rgb;
      if (w_xfer) begin
         w_last_grant_d = w_grant;
         w_we_d         = 1'b1;
         w_x_d          = w_grant ? req1_x   : req0_x;
         w_y_d          = w_grant ? req1_y   : req0_y;
         w_rgb_d        = w_grant ? req1_rgb : req0_rgb;
      end
`ifdef FB_ARB_CLEAR_EN
      w_state_d = r_state;
      w_cx_d    = r_cx;
      w_cy_d    = r_cy;
      w_crgb_d  = r_crgb;
      w_busy_d  = 1'b0;
      if (w_clear_go) begin
         if (r_state == StArb) begin
            w_crgb_d = clear_rgb;
         end
         w_we_d    = 1'b1;
         w_busy_d  = 1'b1;
         w_x_d     = w_pos_x;
         w_y_d     = w_pos_y;
         w_rgb_d   = w_crgb_d;
         w_state_d = StClear;
         if (w_pos_x == XLast) begin
            w_cx_d = 8'd0;
            if (w_pos_y == YLast) begin
               w_cy_d    = 8'd0;
               w_state_d = StArb;
            end else begin
               w_cy_d = w_pos_y + 8'd1;
            end
         end else begin
            w_cx_d = w_pos_x + 8'd1;
            w_cy_d = w_pos_y;
         end
      end
`endif
   end

   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_x          <= 8'd0;
         r_y          <= 8'd0;
         r_rgb        <= 9'd0;
      end else begin
         r_last_grant <= w_last_grant_d;
         r_we         <= w_we_d;
         r_x          <= w_x_d;
         r_y          <= w_y_d;
         r_rgb        <= w_rgb_d;
      end
   end

`ifdef FB_ARB_CLEAR_EN
   always_ff @(posedge clock or negedge not_reset) begin
      if (!not_reset) begin
         r_state <= StArb;
         r_cx    <= 8'd0;
         r_cy    <= 8'd0;
         r_crgb  <= 9'd0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cx    <= w_cx_d;
         r_cy    <= w_cy_d;
         r_crgb  <= w_crgb_d;
         r_busy  <= w_busy_d;
      end
   end
`endif

   assign oX  = r_x;
   assign oY  = r_y;
   assign oR  = r_rgb[8:6];
   assign oG  = r_rgb[5:3];
   assign oB  = r_rgb[2:0];
   assign oWE = r_we;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter on a 4x2 frame; clear expectations follow
// FB_ARB_CLEAR_EN.
module tb_fb_write_arbiter;

   localparam int unsigned W = 4;
   localparam int unsigned H = 2;
`ifdef FB_ARB_CLEAR_EN
   localparam bit Clr = 1'b1;
`else
   localparam bit Clr = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       not_reset = 1'b0;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_x, req0_y, req1_x, req1_y;
   logic [8:0] req0_rgb, req1_rgb, clear_rgb;
   logic       clear_start, clear_busy;
   logic [7:0] oX, oY;
   logic [2:0] oR, oG, oB;
   logic       oWE;

   typedef struct packed {
      logic       we;
      logic       busy;
      logic [7:0] x;
      logic [7:0] y;
      logic [8:0] rgb;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   // Reference model state
   bit         m_last = 1'b1;
   bit         m_clear = 1'b0;
   logic [7:0] m_cx, m_cy;
   logic [8:0] m_crgb;
   logic [7:0] m_x = 8'd0;
   logic [7:0] m_y = 8'd0;
   logic [8:0] m_rgb = 9'd0;
   int         last_g = -1;
   int         busy_cnt;

   fb_write_arbiter #(.FB_W(W), .FB_H(H)) dut (
      .clock      (clock),
      .not_reset  (not_reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_rgb   (req0_rgb),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_rgb   (req1_rgb),
      .clear_start(clear_start),
      .clear_rgb  (clear_rgb),
      .clear_busy (clear_busy),
      .oX         (oX),
      .oY         (oY),
      .oR         (oR),
      .oG         (oG),
      .oB         (oB),
      .oWE        (oWE)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last  = 1'b1;
      m_clear = 1'b0;
      m_x     = 8'd0;
      m_y     = 8'd0;
      m_rgb   = 9'd0;
      last_g  = -1;
      sb_q.delete();
   endtask

   // Called just after a negedge with inputs set; checks readys, predicts the next
   // output cycle, then compares the DUT outputs after the active edge.
   task automatic tick();
      bit   act, g, er0, er1;
      exp_t e, o;
      #1;
      act = m_clear || (Clr && clear_start);
      g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      er0 = !act && req0_valid && !g;
      er1 = !act && req1_valid && g;
      check("req0_ready", 32'(req0_ready), 32'(er0));
      check("req1_ready", 32'(req1_ready), 32'(er1));
      e.we   = 1'b0;
      e.busy = 1'b0;
      last_g = -1;
      if (act) begin
         if (!m_clear) begin
            m_cx    = 8'd0;
            m_cy    = 8'd0;
            m_crgb  = clear_rgb;
            m_clear = 1'b1;
         end
         m_x    = m_cx;
         m_y    = m_cy;
         m_rgb  = m_crgb;
         e.we   = 1'b1;
         e.busy = 1'b1;
         if (32'(m_cx) == W - 1) begin
            m_cx = 8'd0;
            if (32'(m_cy) == H - 1) m_clear = 1'b0;
            else m_cy = m_cy + 8'd1;
         end else begin
            m_cx = m_cx + 8'd1;
         end
      end else if (er0 || er1) begin
         m_last = g;
         last_g = int'(g);
         m_x    = g ? req1_x   : req0_x;
         m_y    = g ? req1_y   : req0_y;
         m_rgb  = g ? req1_rgb : req0_rgb;
         e.we   = 1'b1;
      end
      e.x   = m_x;
      e.y   = m_y;
      e.rgb = m_rgb;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      o = sb_q.pop_front();
      check("oWE", 32'(oWE), 32'(o.we));
      check("clear_busy", 32'(clear_busy), 32'(o.busy));
      check("oX", 32'(oX), 32'(o.x));
      check("oY", 32'(oY), 32'(o.y));
      check("oRGB", 32'({oR, oG, oB}), 32'(o.rgb));
      @(negedge clock);
   endtask

   task automatic new_data();
      req0_x   = 8'($urandom_range(0, 255));
      req0_y   = 8'($urandom_range(0, 255));
      req0_rgb = 9'($urandom);
      req1_x   = 8'($urandom_range(0, 255));
      req1_y   = 8'($urandom_range(0, 255));
      req1_rgb = 9'($urandom);
   endtask

   initial begin
      clear_start = 1'b0;
      clear_rgb   = 9'd0;
      req0_valid  = 1'b1;
      req1_valid  = 1'b1;
      new_data();

      // Reset with both requesters valid
      @(negedge clock);
      @(negedge clock);
      check("rst_oWE", 32'(oWE), 32'd0);
      check("rst_oXY", 32'({oX, oY}), 32'd0);
      check("rst_rgb", 32'({oR, oG, oB}), 32'd0);
      check("rst_busy", 32'(clear_busy), 32'd0);
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      model_reset();
      not_reset = 1'b1;
      tick();
      check("first_grant", 32'(last_g), 32'd0);

      // Single requester
      req0_valid = 1'b0;
      req1_x     = 8'd5;
      req1_y     = 8'd7;
      req1_rgb   = 9'o765;
      tick();
      check("single_we", 32'(oWE), 32'd1);
      check("single_x", 32'(oX), 32'd5);
      check("single_y", 32'(oY), 32'd7);
      check("single_r", 32'(oR), 32'd7);
      check("single_g", 32'(oG), 32'd6);
      check("single_b", 32'(oB), 32'd5);
      req1_valid = 1'b0;
      tick();

      // Contention: strict alternation starting with requester 0
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         new_data();
         tick();
         check("rr_order", 32'(last_g), 32'(i % 2));
         check("rr_we", 32'(oWE), 32'd1);
      end

      // Clear with both requesters held valid
      new_data();
      clear_rgb   = 9'o123;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      busy_cnt    = int'(clear_busy);
      for (int i = 0; i < int'(W * H); i++) begin
         tick();
         busy_cnt += int'(clear_busy);
      end
      check("clear_busy_cycles", 32'(busy_cnt), Clr ? 32'(W * H) : 32'd0);
      for (int i = 0; i < 3; i++) tick();

      // Clear coincident with a request, then reset at the third clear write
      req1_valid  = 1'b0;
      req0_valid  = 1'b1;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      tick();
      tick();
      not_reset = 1'b0;
      #1;
      check("abort_oWE", 32'(oWE), 32'd0);
      check("abort_busy", 32'(clear_busy), 32'd0);
      model_reset();
      @(negedge clock);
      not_reset = 1'b1;
      new_data();
      tick();
      check("post_abort_we", 32'(oWE), 32'd1);
      check("post_abort_x", 32'(oX), 32'(req0_x));
      req0_valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
